// File: rtl/detector_share_ctrl.sv
// Shares one S0..S3 ones-count detector across N requesters: round-robin grant,
// per-channel private state, read/advance/write-back in a 3-cycle service.
module detector_share_ctrl #(
    parameter int N  = 4,
    parameter int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic [N-1:0]  req_i,
    input  logic [N-1:0]  ain_i,
    input  logic [N-1:0]  clr_i,
    output logic [N-1:0]  gnt_o,
    output logic          out_valid_o,
    output logic [CW-1:0] out_chan_o,
    output logic          out_hit_o,
    output logic          busy_o
);

    typedef enum logic [1:0] {IDLE, GRANT, UPDATE} ctrl_t;
    typedef enum logic [1:0] {S0, S1, S2, S3} det_t;

    ctrl_t         ctrl_q, ctrl_d;
    logic [CW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] chan_q, chan_d;
    logic          samp_q, samp_d;
    det_t          cur_q, cur_d;

    det_t          ch_state [N];
    det_t          det_next;
    logic          det_hit;

    // Candidate k of the round-robin search is channel (ptr + k) mod N.
    logic [CW-1:0] cand_idx [N];
    logic [N-1:0]  cand_req;
    logic [CW-1:0] sel_idx;

    for (genvar gi = 0; gi < N; gi++) begin : g_cand
        logic [CW:0] sum_w;
        assign sum_w         = {1'b0, ptr_q} + (CW+1)'(gi);
        assign cand_idx[gi]  = (sum_w >= (CW+1)'(N)) ? CW'(sum_w - (CW+1)'(N))
                                                     : sum_w[CW-1:0];
        assign cand_req[gi]  = req_i[cand_idx[gi]];
    end

    always_comb begin
        sel_idx = ptr_q;
        for (int k = N - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                sel_idx = cand_idx[k];
            end
        end
    end

    // Shared detector: only a 1 sample advances; S3 restarts the count at S1.
    always_comb begin
        det_next = cur_q;
        if (samp_q) begin
            case (cur_q)
                S0:      det_next = S1;
                S1:      det_next = S2;
                S2:      det_next = S3;
                default: det_next = S1;
            endcase
        end
        det_hit = (cur_q == S2) && samp_q;
    end

    // Per-channel state; a clear in the write-back cycle overrides the write.
    for (genvar gi = 0; gi < N; gi++) begin : g_chan
        det_t st_q;
        always_ff @(posedge clock_i or posedge reset_i) begin
            if (reset_i) begin
                st_q <= S0;
            end else if (clr_i[gi]) begin
                st_q <= S0;
            end else if ((ctrl_q == UPDATE) && (chan_q == CW'(gi))) begin
                st_q <= det_next;
            end
        end
        assign ch_state[gi] = st_q;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            ctrl_q <= IDLE;
            ptr_q  <= '0;
            chan_q <= '0;
            samp_q <= 1'b0;
            cur_q  <= S0;
        end else begin
            ctrl_q <= ctrl_d;
            ptr_q  <= ptr_d;
            chan_q <= chan_d;
            samp_q <= samp_d;
            cur_q  <= cur_d;
        end
    end

    always_comb begin
        ctrl_d      = ctrl_q;
        ptr_d       = ptr_q;
        chan_d      = chan_q;
        samp_d      = samp_q;
        cur_d       = cur_q;
        gnt_o       = '0;
        out_valid_o = 1'b0;
        out_chan_o  = '0;
        out_hit_o   = 1'b0;
        case (ctrl_q)
            IDLE: begin
                if (|req_i) begin
                    chan_d = sel_idx;
                    samp_d = ain_i[sel_idx];
                    ctrl_d = GRANT;
                end
            end
            GRANT: begin
                gnt_o[chan_q] = 1'b1;
                cur_d         = ch_state[chan_q];
                ctrl_d        = UPDATE;
            end
            UPDATE: begin
                out_valid_o = 1'b1;
                out_chan_o  = chan_q;
                out_hit_o   = det_hit;
                ptr_d       = (chan_q == CW'(N - 1)) ? '0 : chan_q + 1'b1;
                ctrl_d      = IDLE;
            end
            default: ctrl_d = IDLE;
        endcase
    end

    assign busy_o = (ctrl_q != IDLE);

endmodule

// File: tb/tb_detector_share_ctrl.sv
// Directed + randomized bench for detector_share_ctrl against a per-service
// transaction model (round-robin pointer and per-channel counts in arrays).
module tb_detector_share_ctrl;

    localparam int N  = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req, ain, clr;
    logic [N-1:0]  gnt;
    logic          out_valid, out_hit, busy;
    logic [CW-1:0] out_chan;

    int checks = 0;
    int errors = 0;

    int mstate [N];
    int mptr;

    detector_share_ctrl #(.N(N), .CW(CW)) dut (
        .clock_i    (clk),
        .reset_i    (reset),
        .req_i      (req),
        .ain_i      (ain),
        .clr_i      (clr),
        .gnt_o      (gnt),
        .out_valid_o(out_valid),
        .out_chan_o (out_chan),
        .out_hit_o  (out_hit),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) mstate[i] = 0;
        mptr = 0;
    endtask

    function automatic int pick(input logic [N-1:0] mask);
        for (int k = 0; k < N; k++) begin
            if (mask[(mptr + k) % N]) return (mptr + k) % N;
        end
        return -1;
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with it idle again.
    task automatic service(input logic [N-1:0] mask, input logic [N-1:0] bits,
                           input logic [N-1:0] clr_upd, input bit hold);
        int       ch;
        int       old;
        logic     exp_hit;
        logic [N-1:0] onehot;
        ch     = pick(mask);
        onehot = '0;
        onehot[ch] = 1'b1;
        req = mask;
        ain = bits;
        clr = '0;
        chk("busy_before", busy, 0);
        @(negedge clk);
        chk("gnt", gnt, onehot);
        chk("busy_grant", busy, 1);
        chk("valid_grant", out_valid, 0);
        if (!hold) begin
            req = N'($urandom_range(0, (1 << N) - 1));
            ain = N'($urandom_range(0, (1 << N) - 1));
        end
        @(negedge clk);
        old     = mstate[ch];
        exp_hit = (old == 2) && bits[ch];
        chk("out_valid", out_valid, 1);
        chk("out_chan", out_chan, ch);
        chk("out_hit", out_hit, exp_hit);
        chk("gnt_update", gnt, 0);
        clr = clr_upd;
        @(negedge clk);
        clr = '0;
        if (bits[ch]) mstate[ch] = (old == 3) ? 1 : old + 1;
        for (int i = 0; i < N; i++) if (clr_upd[i]) mstate[i] = 0;
        mptr = (ch + 1) % N;
        $display("svc mask=%b ain=%b clr=%b chan=%0d hit=%0d", mask, bits, clr_upd, ch, exp_hit);
    endtask

    task automatic idle_cycle(input logic [N-1:0] c);
        req = '0;
        clr = c;
        @(negedge clk);
        clr = '0;
        chk("idle_busy", busy, 0);
        chk("idle_gnt", gnt, 0);
        for (int i = 0; i < N; i++) if (c[i]) mstate[i] = 0;
        $display("idle clr=%b", c);
    endtask

    initial begin
        logic [N-1:0] m, b, c;
        reset = 1'b1;
        req   = '0;
        ain   = '0;
        clr   = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_chan", out_chan, 0);
        chk("rst_hit", out_hit, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        @(negedge clk);

        // Single service on ch0
        service(4'b0001, 4'b0001, 4'b0000, 1'b0);

        // ch2: ones give hit on third, not fourth
        repeat (4) service(4'b0100, 4'b0100, 4'b0000, 1'b0);

        // All channels requesting, held
        for (int i = 0; i < 5; i++) service(4'b1111, N'($urandom_range(0, 15)), 4'b0000, 1'b1);

        // Pointer wrap: after ch1, 0011 grants 0 then 1
        service(4'b0010, 4'b0000, 4'b0000, 1'b0);
        service(4'b0011, 4'b0000, 4'b0000, 1'b0);
        service(4'b0011, 4'b0000, 4'b0000, 1'b0);

        // ch3 to S2, then hit with clear in the write-back cycle
        idle_cycle(4'b1000);
        service(4'b1000, 4'b1000, 4'b0000, 1'b0);
        service(4'b1000, 4'b1000, 4'b0000, 1'b0);
        service(4'b1000, 4'b1000, 4'b1000, 1'b0);
        service(4'b1000, 4'b1000, 4'b0000, 1'b0);
        service(4'b1000, 4'b1000, 4'b0000, 1'b0);
        service(4'b1000, 4'b1000, 4'b0000, 1'b0);

        // Randomized traffic
        for (int t = 0; t < 80; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                c = ($urandom_range(0, 1) == 0) ? N'($urandom_range(0, 15)) : '0;
                idle_cycle(c);
            end
            m = N'($urandom_range(1, 15));
            b = N'($urandom_range(0, 15));
            c = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : '0;
            service(m, b, c, 1'($urandom_range(0, 1)));
        end

        // Reset during GRANT with ch2 sitting at S2
        for (int i = 0; i < 4 && mstate[2] != 2; i++) service(4'b0100, 4'b0100, 4'b0000, 1'b0);
        chk("pre_reset_s2", mstate[2], 2);
        req = 4'b0100;
        ain = 4'b0100;
        @(negedge clk);
        chk("gnt_before_abort", gnt, 4'b0100);
        reset = 1'b1;
        #1;
        chk("abort_gnt", gnt, 0);
        chk("abort_busy", busy, 0);
        chk("abort_valid", out_valid, 0);
        @(negedge clk);
        chk("abort_valid_late", out_valid, 0);
        chk("abort_gnt_late", gnt, 0);
        reset = 1'b0;
        req   = '0;
        model_reset();
        $display("reset during grant");
        service(4'b1111, 4'b0100, 4'b0000, 1'b0);
        service(4'b0100, 4'b0100, 4'b0000, 1'b0);
        service(4'b0100, 4'b0100, 4'b0000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
